// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, imem fetch handshake, skid buffer and IF/ID register
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic            flush_if_id,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid
);

  logic [XLEN-1:0] r_pc;
  logic            r_run;
  logic            r_outstanding;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_instr;
  logic            r_drop_pending;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] r_if_id_pc;
  logic [XLEN-1:0] r_if_id_instr;
  logic            r_if_id_valid;

  logic            w_req;
  logic            w_accept;
  logic            w_in_flight;
  logic            w_redirect;
  logic            w_keep_word;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jalr_aligned;

  // A request stays up while outstanding even under stall; a full skid blocks new fetches.
  assign w_req          = r_run & ~r_skid_valid & (r_outstanding | ~stall);
  assign w_accept       = w_req & imem_ready;
  // Request visible this cycle but not taken: address must not move under it.
  assign w_in_flight    = w_req & ~imem_ready;
  assign w_redirect     = (pc_sel != 2'b11);
  // Accepted word is only kept when it is on the architectural path.
  assign w_keep_word    = w_accept & ~w_redirect & ~r_drop_pending;
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_jalr_aligned = jalr_target & ~{{(XLEN-1){1'b0}}, 1'b1};

  // Select the redirect target from the branch/jump unit.
  always_comb begin
    w_target = branch_target;
    case (pc_sel)
      2'b00:   w_target = branch_target;
      2'b01:   w_target = w_jalr_aligned;
      2'b10:   w_target = jal_target;
      default: w_target = branch_target;
    endcase
  end

  // PC, run, outstanding and pending-redirect tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc           <= RESET_PC;
      r_run          <= 1'b0;
      r_outstanding  <= 1'b0;
      r_drop_pending <= 1'b0;
      r_pend_pc      <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_in_flight;
      if (w_redirect) begin
        if (w_in_flight) begin
          // Newest target wins; it is applied when the in-flight fetch returns.
          r_pend_pc      <= w_target;
          r_drop_pending <= 1'b1;
        end else begin
          r_pc           <= w_target;
          r_drop_pending <= 1'b0;
        end
      end else if (w_accept) begin
        r_pc           <= r_drop_pending ? r_pend_pc : w_pc_plus4;
        r_drop_pending <= 1'b0;
      end
    end
  end

  // Skid buffer and IF/ID register; flush beats stall and any load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_valid  <= 1'b0;
      r_skid_pc     <= '0;
      r_skid_instr  <= '0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else begin
      if (flush_if_id || (w_redirect && !w_in_flight)) begin
        r_skid_valid <= 1'b0;
      end else if (w_keep_word && stall) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= r_pc;
        r_skid_instr <= imem_rdata;
      end else if (!stall && r_skid_valid) begin
        r_skid_valid <= 1'b0;
      end

      if (flush_if_id) begin
        r_if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (r_skid_valid && !w_redirect) begin
          r_if_id_valid <= 1'b1;
          r_if_id_pc    <= r_skid_pc;
          r_if_id_instr <= r_skid_instr;
        end else if (w_keep_word) begin
          r_if_id_valid <= 1'b1;
          r_if_id_pc    <= r_pc;
          r_if_id_instr <= imem_rdata;
        end else begin
          r_if_id_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] jal_target;
  logic        flush_if_id;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int n_checks;
  int n_fails;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .jal_target    (jal_target),
    .flush_if_id   (flush_if_id),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    reset_n       = 1'b0;
    pc_sel        = 2'b11;
    branch_target = '0;
    jalr_target   = '0;
    jal_target    = '0;
    flush_if_id   = 1'b0;
    stall         = 1'b0;
    imem_ready    = 1'b1;

    step();
    step();
    check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr",  imem_addr, 32'h0);
    check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    reset_n = 1'b1;
    check_eq("rel_req0",  {31'd0, imem_req}, 32'd0);

    // sequential fetch
    step();
    check_eq("seq_req",    {31'd0, imem_req}, 32'd1);
    check_eq("seq_addr0",  imem_addr, 32'h0);
    check_eq("seq_valid0", {31'd0, if_id_valid}, 32'd0);
    step();
    check_eq("seq_addr4",  imem_addr, 32'h4);
    check_eq("seq_ifpc0",  if_id_pc, 32'h0);
    check_eq("seq_instr0", if_id_instr, 32'h1300_0013);
    check_eq("seq_valid1", {31'd0, if_id_valid}, 32'd1);
    step();
    check_eq("seq_addr8",  imem_addr, 32'h8);
    check_eq("seq_ifpc4",  if_id_pc, 32'h4);
    step();
    step();
    check_eq("seq_addr10", imem_addr, 32'h10);
    check_eq("seq_ifpcC",  if_id_pc, 32'hC);

    // branch with flush while word at 0x10 is accepted
    pc_sel = 2'b00; branch_target = 32'h40; flush_if_id = 1'b1;
    step();
    pc_sel = 2'b11; flush_if_id = 1'b0;
    check_eq("br_addr",   imem_addr, 32'h40);
    check_eq("br_valid0", {31'd0, if_id_valid}, 32'd0);
    step();
    check_eq("br_ifpc",   if_id_pc, 32'h40);
    check_eq("br_valid1", {31'd0, if_id_valid}, 32'd1);
    check_eq("br_addr44", imem_addr, 32'h44);

    // redirect to 0x20 then hold request there with ready low
    pc_sel = 2'b00; branch_target = 32'h20;
    step();
    pc_sel = 2'b11; imem_ready = 1'b0;
    step();
    check_eq("hold_addr", imem_addr, 32'h20);
    check_eq("hold_req",  {31'd0, imem_req}, 32'd1);
    pc_sel = 2'b10; jal_target = 32'h100;
    step();
    pc_sel = 2'b11; stall = 1'b1;
    check_eq("pend_addr", imem_addr, 32'h20);
    check_eq("pend_req_stall", {31'd0, imem_req}, 32'd1);
    step();
    check_eq("pend_addr2", imem_addr, 32'h20);
    check_eq("pend_valid", {31'd0, if_id_valid}, 32'd0);
    stall = 1'b0; imem_ready = 1'b1;
    step();
    check_eq("drop_addr",  imem_addr, 32'h100);
    check_eq("drop_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check_eq("jal_ifpc",  if_id_pc, 32'h100);
    check_eq("jal_valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("jal_addr",  imem_addr, 32'h104);

    // stall while word at 0x30 is accepted -> skid buffer
    pc_sel = 2'b00; branch_target = 32'h2C;
    step();
    pc_sel = 2'b11;
    step();
    check_eq("pre_skid_ifpc", if_id_pc, 32'h2C);
    check_eq("pre_skid_addr", imem_addr, 32'h30);
    imem_ready = 1'b0;
    step();
    stall = 1'b1; imem_ready = 1'b1;
    check_eq("skid_req_out", {31'd0, imem_req}, 32'd1);
    step();
    check_eq("skid_req0",   {31'd0, imem_req}, 32'd0);
    check_eq("skid_addr",   imem_addr, 32'h34);
    check_eq("skid_ifpc",   if_id_pc, 32'h2C);
    check_eq("skid_instr",  if_id_instr, instr_of(32'h2C));
    check_eq("skid_valid0", {31'd0, if_id_valid}, 32'd0);
    step();
    check_eq("skid_hold_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    check_eq("skid_drain_req", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("drain_ifpc",  if_id_pc, 32'h30);
    check_eq("drain_instr", if_id_instr, instr_of(32'h30));
    check_eq("drain_valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("drain_req",   {31'd0, imem_req}, 32'd1);
    check_eq("drain_addr",  imem_addr, 32'h34);
    step();
    check_eq("post_ifpc", if_id_pc, 32'h34);

    // JALR clears bit 0 only
    pc_sel = 2'b01; jalr_target = 32'h203;
    step();
    pc_sel = 2'b11;
    check_eq("jalr_addr", imem_addr, 32'h202);
    step();
    check_eq("jalr_ifpc", if_id_pc, 32'h202);
    check_eq("jalr_next", imem_addr, 32'h206);

    // asynchronous reset with outstanding request and pending redirect
    imem_ready = 1'b0;
    step();
    pc_sel = 2'b10; jal_target = 32'h500;
    step();
    pc_sel = 2'b11;
    check_eq("ar_pend_addr", imem_addr, 32'h206);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("ar_req",   {31'd0, imem_req}, 32'd0);
    check_eq("ar_addr",  imem_addr, 32'h0);
    check_eq("ar_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("ar_ifpc",  if_id_pc, 32'h0);
    imem_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    check_eq("ar2_req",  {31'd0, imem_req}, 32'd1);
    check_eq("ar2_addr", imem_addr, 32'h0);
    step();
    check_eq("ar2_ifpc",  if_id_pc, 32'h0);
    check_eq("ar2_valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("ar2_addr4", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
